// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the two-port SRAM request arbiter: owner encoding,
// in-flight entry layout and the legal SRAM read-latency range.
package sram_req_arbiter_pkg;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
    logic is_write;
  } inflight_t;

  function automatic bit sram_lat_legal(int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/sram_inflight_pipe.sv
// LAT-deep shift register of granted accesses; the tail entry decodes into
// the per-owner response strobe.
module sram_inflight_pipe
  import sram_req_arbiter_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  inflight_t push,
  output logic      i_resp,
  output logic      d_resp
);

  inflight_t stages [LAT];
  inflight_t tail;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LAT; k++) stages[k] <= '0;
    end else begin
      stages[0] <= push;
      for (int k = 1; k < LAT; k++) stages[k] <= stages[k-1];
    end
  end

  assign tail = stages[LAT-1];

  // Fetch entries never carry is_write, so a write-tagged I entry is not a fetch response.
  assign i_resp = tail.valid && (tail.owner == OWN_I) && !tail.is_write;
  assign d_resp = tail.valid && (tail.owner == OWN_D);

endmodule

// File: rtl/sram_req_arbiter.sv
// Arbitrates fetch (I) and load/store (D) onto one single-port SRAM and routes
// responses back in grant order. Define SRAM_ARB_RR_EN for round-robin arbitration.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int SRAM_LAT = 1,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [3:0]        d_wstrb,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [31:0]       d_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  if (!sram_lat_legal(SRAM_LAT)) begin : g_bad_lat
    $error("sram_req_arbiter: SRAM_LAT must be 1 or 2");
  end

  logic      pick_d;
  logic      i_resp;
  logic      d_resp;
  inflight_t push;

`ifdef SRAM_ARB_RR_EN
  logic last_grant;

  // On a conflict the port that did not win last time goes first.
  always_comb begin
    pick_d = d_req && (!i_req || (last_grant == OWN_I));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= OWN_D;
    end else if (i_addr_ok || d_addr_ok) begin
      last_grant <= d_addr_ok ? OWN_D : OWN_I;
    end
  end
`else
  always_comb begin
    pick_d = d_req;
  end
`endif

  // No handshakes complete while reset is held; the tracking is being cleared anyway.
  assign d_addr_ok = !reset && pick_d;
  assign i_addr_ok = !reset && i_req && !pick_d;

  assign sram_en    = i_addr_ok || d_addr_ok;
  assign sram_we    = (d_addr_ok && d_wr) ? d_wstrb : 4'b0000;
  assign sram_addr  = d_addr_ok ? d_addr : i_addr;
  assign sram_wdata = d_addr_ok ? d_wdata : 32'h0;

  always_comb begin
    push          = '0;
    push.valid    = sram_en;
    push.owner    = d_addr_ok ? OWN_D : OWN_I;
    push.is_write = d_addr_ok && d_wr;
  end

  sram_inflight_pipe #(
    .LAT (SRAM_LAT)
  ) u_pipe (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .i_resp (i_resp),
    .d_resp (d_resp)
  );

  assign i_data_ok = !reset && i_resp;
  assign d_data_ok = !reset && d_resp;
  assign i_rdata   = sram_rdata;
  assign d_rdata   = sram_rdata;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: one SRAM_LAT=1 and one SRAM_LAT=2 instance
// share stimulus, each backed by its own behavioural SRAM read pipeline.
module tb_sram_req_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        i_req, d_req, d_wr;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;

  logic        i_addr_ok1, i_data_ok1, d_addr_ok1, d_data_ok1, sram_en1;
  logic [31:0] i_rdata1, d_rdata1, sram_addr1, sram_wdata1, sram_rdata1;
  logic [3:0]  sram_we1;
  logic        i_addr_ok2, i_data_ok2, d_addr_ok2, d_data_ok2, sram_en2;
  logic [31:0] i_rdata2, d_rdata2, sram_addr2, sram_wdata2, sram_rdata2;
  logic [3:0]  sram_we2;

  int n_cmp = 0;
  int n_err = 0;

  sram_req_arbiter #(.SRAM_LAT(1), .ADDR_W(32)) u_lat1 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok1), .i_data_ok(i_data_ok1), .i_rdata(i_rdata1),
    .d_req(d_req), .d_wr(d_wr), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok1), .d_data_ok(d_data_ok1), .d_rdata(d_rdata1),
    .sram_en(sram_en1), .sram_we(sram_we1), .sram_addr(sram_addr1), .sram_wdata(sram_wdata1),
    .sram_rdata(sram_rdata1)
  );

  sram_req_arbiter #(.SRAM_LAT(2), .ADDR_W(32)) u_lat2 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok2), .i_data_ok(i_data_ok2), .i_rdata(i_rdata2),
    .d_req(d_req), .d_wr(d_wr), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok2), .d_data_ok(d_data_ok2), .d_rdata(d_rdata2),
    .sram_en(sram_en2), .sram_we(sram_we2), .sram_addr(sram_addr2), .sram_wdata(sram_wdata2),
    .sram_rdata(sram_rdata2)
  );

  // Behavioural SRAM: unwritten words read back as addr ^ 32'h5A5A0000.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd2_stage;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  always @(posedge clk) begin
    logic [31:0] w;
    if (sram_en1) sram_rdata1 <= mem_rd(sram_addr1);
    if (sram_en2) rd2_stage <= mem_rd(sram_addr2);
    sram_rdata2 <= rd2_stage;
    if (sram_en1 && (sram_we1 != 4'b0000)) begin
      w = mem_rd(sram_addr1);
      for (int b = 0; b < 4; b++) if (sram_we1[b]) w[8*b +: 8] = sram_wdata1[8*b +: 8];
      mem[sram_addr1] = w;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    #3;
    n_cmp++; if (sram_en1 !== 1'b0) begin n_err++; $display("FAIL reset_sram_en: got %b want 0", sram_en1); end
    n_cmp++; if (sram_we1 !== 4'b0) begin n_err++; $display("FAIL reset_sram_we: got %b want 0000", sram_we1); end
    n_cmp++; if ({i_data_ok1, d_data_ok1, i_data_ok2, d_data_ok2} !== 4'b0) begin n_err++; $display("FAIL reset_data_ok: got %b want 0000", {i_data_ok1, d_data_ok1, i_data_ok2, d_data_ok2}); end
    n_cmp++; if ({i_addr_ok1, d_addr_ok1} !== 2'b0) begin n_err++; $display("FAIL reset_addr_ok: got %b want 00", {i_addr_ok1, d_addr_ok1}); end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_fetch();
    mem[32'h1C00_0000] = 32'h0280_0400;
    tick();
    i_req = 1'b1; i_addr = 32'h1C00_0000; #3;
    n_cmp++; if (i_addr_ok1 !== 1'b1) begin n_err++; $display("FAIL fetch_addr_ok: got %b want 1", i_addr_ok1); end
    n_cmp++; if (sram_en1 !== 1'b1) begin n_err++; $display("FAIL fetch_sram_en: got %b want 1", sram_en1); end
    n_cmp++; if (sram_we1 !== 4'b0) begin n_err++; $display("FAIL fetch_sram_we: got %b want 0000", sram_we1); end
    n_cmp++; if (sram_addr1 !== 32'h1C00_0000) begin n_err++; $display("FAIL fetch_sram_addr: got %h want 1c000000", sram_addr1); end
    tick();
    i_req = 1'b0; #3;
    n_cmp++; if (i_data_ok1 !== 1'b1) begin n_err++; $display("FAIL fetch_data_ok: got %b want 1", i_data_ok1); end
    n_cmp++; if (i_rdata1 !== 32'h0280_0400) begin n_err++; $display("FAIL fetch_rdata: got %h want 02800400", i_rdata1); end
    n_cmp++; if (d_data_ok1 !== 1'b0) begin n_err++; $display("FAIL fetch_d_data_ok: got %b want 0", d_data_ok1); end
    tick(); #3;
    n_cmp++; if (i_data_ok1 !== 1'b0) begin n_err++; $display("FAIL fetch_single_pulse: got %b want 0", i_data_ok1); end
    idle(3);
  endtask

  task automatic test_conflict();
    do_reset();
    tick();
    i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h100; #3;
`ifdef SRAM_ARB_RR_EN
    n_cmp++; if ({i_addr_ok1, d_addr_ok1} !== 2'b10) begin n_err++; $display("FAIL conflict_grant0: got i,d=%b want 10", {i_addr_ok1, d_addr_ok1}); end
    tick();
    i_req = 1'b0; #3;
    n_cmp++; if ({i_addr_ok1, d_addr_ok1} !== 2'b01) begin n_err++; $display("FAIL conflict_grant1: got i,d=%b want 01", {i_addr_ok1, d_addr_ok1}); end
    n_cmp++; if (i_data_ok1 !== 1'b1 || i_rdata1 !== 32'h5A5A_0040) begin n_err++; $display("FAIL conflict_i_resp: got ok=%b data=%h want 1/5a5a0040", i_data_ok1, i_rdata1); end
    tick();
    d_req = 1'b0; #3;
    n_cmp++; if (d_data_ok1 !== 1'b1 || d_rdata1 !== 32'h5A5A_0100) begin n_err++; $display("FAIL conflict_d_resp: got ok=%b data=%h want 1/5a5a0100", d_data_ok1, d_rdata1); end
`else
    n_cmp++; if ({i_addr_ok1, d_addr_ok1} !== 2'b01) begin n_err++; $display("FAIL conflict_grant0: got i,d=%b want 01", {i_addr_ok1, d_addr_ok1}); end
    tick();
    d_req = 1'b0; #3;
    n_cmp++; if ({i_addr_ok1, d_addr_ok1} !== 2'b10) begin n_err++; $display("FAIL conflict_grant1: got i,d=%b want 10", {i_addr_ok1, d_addr_ok1}); end
    n_cmp++; if (d_data_ok1 !== 1'b1 || d_rdata1 !== 32'h5A5A_0100) begin n_err++; $display("FAIL conflict_d_resp: got ok=%b data=%h want 1/5a5a0100", d_data_ok1, d_rdata1); end
    tick();
    i_req = 1'b0; #3;
    n_cmp++; if (i_data_ok1 !== 1'b1 || i_rdata1 !== 32'h5A5A_0040) begin n_err++; $display("FAIL conflict_i_resp: got ok=%b data=%h want 1/5a5a0040", i_data_ok1, i_rdata1); end
    n_cmp++; if (d_data_ok1 !== 1'b0) begin n_err++; $display("FAIL conflict_d_quiet: got %b want 0", d_data_ok1); end
`endif
    idle(3);
  endtask

  task automatic test_store();
    tick();
    d_req = 1'b1; d_wr = 1'b1; d_wstrb = 4'b0011; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; #3;
    n_cmp++; if (d_addr_ok1 !== 1'b1) begin n_err++; $display("FAIL store_addr_ok: got %b want 1", d_addr_ok1); end
    n_cmp++; if (sram_we1 !== 4'b0011) begin n_err++; $display("FAIL store_we: got %b want 0011", sram_we1); end
    n_cmp++; if (sram_addr1 !== 32'h200) begin n_err++; $display("FAIL store_addr: got %h want 00000200", sram_addr1); end
    n_cmp++; if (sram_wdata1 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL store_wdata: got %h want deadbeef", sram_wdata1); end
    tick();
    d_wr = 1'b0; #3;
    n_cmp++; if (d_data_ok1 !== 1'b1) begin n_err++; $display("FAIL store_done: got %b want 1", d_data_ok1); end
    n_cmp++; if (sram_we1 !== 4'b0) begin n_err++; $display("FAIL load_we: got %b want 0000", sram_we1); end
    tick();
    d_req = 1'b0; #3;
    n_cmp++; if (d_data_ok1 !== 1'b1 || d_rdata1 !== 32'h5A5A_BEEF) begin n_err++; $display("FAIL store_readback: got ok=%b data=%h want 1/5a5abeef", d_data_ok1, d_rdata1); end
    idle(3);
  endtask

  task automatic test_lat2_pipeline();
    logic [31:0] exp_q[$];
    tick();
    i_req = 1'b1; i_addr = 32'h0; #3;
    n_cmp++; if (i_addr_ok2 !== 1'b1) begin n_err++; $display("FAIL lat2_grant0: got %b want 1", i_addr_ok2); end
    tick();
    i_addr = 32'h4; #3;
    n_cmp++; if (i_data_ok2 !== 1'b0) begin n_err++; $display("FAIL lat2_early: got %b want 0", i_data_ok2); end
    n_cmp++; if (i_data_ok1 !== 1'b1 || i_rdata1 !== 32'h5A5A_0000) begin n_err++; $display("FAIL lat1_stream0: got ok=%b data=%h want 1/5a5a0000", i_data_ok1, i_rdata1); end
    tick();
    i_addr = 32'h8; #3;
    exp_q = '{32'h5A5A_0000, 32'h5A5A_0004, 32'h5A5A_0008};
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (i_data_ok2 !== 1'b1 || i_rdata2 !== exp_q[c]) begin n_err++; $display("FAIL lat2_resp%0d: got ok=%b data=%h want 1/%h", c, i_data_ok2, i_rdata2, exp_q[c]); end
      tick();
      i_req = 1'b0; #3;
    end
    n_cmp++; if (i_data_ok2 !== 1'b0) begin n_err++; $display("FAIL lat2_drain: got %b want 0", i_data_ok2); end
    idle(3);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_i;
`ifdef SRAM_ARB_RR_EN
    exp_i = 4'b0101;
`else
    exp_i = 4'b0000;
`endif
    do_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      i_req = 1'b1; i_addr = 32'h1000 + 32'(4 * c);
      d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h2000 + 32'(4 * c); #3;
      n_cmp++; if ({i_addr_ok1, d_addr_ok1} !== {exp_i[c], ~exp_i[c]}) begin n_err++; $display("FAIL arb_cycle%0d: got i,d=%b want %b", c, {i_addr_ok1, d_addr_ok1}, {exp_i[c], ~exp_i[c]}); end
    end
    idle(4);
  endtask

  task automatic test_reset_midflight();
    tick();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h300; #3;
    n_cmp++; if (d_addr_ok1 !== 1'b1 || d_addr_ok2 !== 1'b1) begin n_err++; $display("FAIL mid_grant: got %b%b want 11", d_addr_ok1, d_addr_ok2); end
    tick();
    d_req = 1'b0; reset = 1'b1; #3;
    n_cmp++; if ({d_data_ok1, d_data_ok2} !== 2'b00) begin n_err++; $display("FAIL mid_c1_data_ok: got %b want 00", {d_data_ok1, d_data_ok2}); end
    tick();
    reset = 1'b0; #3;
    n_cmp++; if ({i_addr_ok1, d_addr_ok1, i_data_ok1, d_data_ok1, sram_en1, sram_we1} !== 9'b0) begin n_err++; $display("FAIL mid_c2_lat1_outputs: got %b want 0", {i_addr_ok1, d_addr_ok1, i_data_ok1, d_data_ok1, sram_en1, sram_we1}); end
    n_cmp++; if ({i_addr_ok2, d_addr_ok2, i_data_ok2, d_data_ok2, sram_en2, sram_we2} !== 9'b0) begin n_err++; $display("FAIL mid_c2_lat2_outputs: got %b want 0", {i_addr_ok2, d_addr_ok2, i_data_ok2, d_data_ok2, sram_en2, sram_we2}); end
    tick(); #3;
    n_cmp++; if ({d_data_ok1, d_data_ok2} !== 2'b00) begin n_err++; $display("FAIL mid_c3_data_ok: got %b want 00", {d_data_ok1, d_data_ok2}); end
    idle(2);
  endtask

  initial begin
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_wr = 1'b0; d_wstrb = '0; d_addr = '0; d_wdata = '0;
    test_reset();
    test_fetch();
    test_conflict();
    test_store();
    test_lat2_pipeline();
    test_round_robin();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one single-port synchronous SRAM between two requesters: instruction fetch (port I) and load/store from EXE (port D).
- Each requester uses a req/addr_ok/data_ok handshake; the SRAM side matches the existing data_sram_en/we/addr/wdata interface.
- Grants at most one request per cycle and tracks in-flight reads, so every response returns to its owner in order.
- Sits between the IF/EXE/MEM stages and the unified memory.

Parameters:
- SRAM_LAT, 1, SRAM read latency in cycles from en to valid rdata; legal values 1 or 2.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_req  in  1  fetch request valid
- i_addr  in  ADDR_W  fetch address
- i_addr_ok  out  1  fetch request accepted this cycle
- i_data_ok  out  1  fetch read data valid on i_rdata
- i_rdata  out  32  fetch read data
- d_req  in  1  data request valid
- d_wr  in  1  1 = store, 0 = load
- d_wstrb  in  4  store byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  store data
- d_addr_ok  out  1  data request accepted this cycle
- d_data_ok  out  1  load data valid, or store completed
- d_rdata  out  32  load data
- sram_en  out  1  SRAM access enable
- sram_we  out  4  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data

Behaviour:
- Clock clk; reset is synchronous, active-high (named reset).
- Requester rules:
  - A requester holds req and all request fields stable until the cycle its addr_ok=1.
  - Requesters always accept data_ok; there is no response backpressure.
- Grant:
  - Combinational, same cycle.
  - Exactly one of i_addr_ok/d_addr_ok is 1 when at least one req is 1; both are 0 otherwise.
  - Fixed priority: D wins over I.
- SRAM drive:
  - sram_en = i_addr_ok | d_addr_ok.
  - sram_addr/sram_wdata come from the granted port.
  - sram_we = d_addr_ok & d_wr ? d_wstrb : 4'b0.
  - A fetch grant never writes.
- In-flight tracking: a shift register of SRAM_LAT stages, each holding {valid, owner, is_write}, shifted every cycle. Stage 0 loads the grant of the current cycle.
- Response:
  - When the final stage is valid, that owner's data_ok=1 for exactly one cycle.
  - i_rdata and d_rdata = sram_rdata, passed through combinationally; contents are don't-care when data_ok=0.
- Latency:
  - Request accepted in cycle N gives data_ok in cycle N+SRAM_LAT.
  - Stores also get data_ok at N+SRAM_LAT (completion); d_rdata is don't-care for stores.
- Throughput: one grant per cycle, fully pipelined. Responses come back in grant order.
- Simultaneous events:
  - A new grant and a response in the same cycle are both legal.
  - A response to I and a grant to D in the same cycle are independent.
- Starvation: under fixed priority, continuous d_req stalls I indefinitely. This is acceptable because EXE cannot issue back-to-back without pipeline advance.
- Reset:
  - All tracking stages are cleared, and the round-robin pointer is reset to point at D.
  - All outputs read 0 the cycle after reset is sampled: addr_ok, data_ok, sram_en, sram_we.
  - Reset mid-transaction drops outstanding responses; no data_ok is issued for them.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last_grant register updates on every grant.
  - When both req=1, the port not granted last wins; a lone requester always wins.
  - last_grant resets to D, so I wins the first conflict.
- Undefined: fixed D-over-I priority; no last_grant register exists.

Decomposition:
- Shared package/header:
  - Owner encoding constants: OWN_I=0, OWN_D=1.
  - The in-flight entry width/layout.
  - The SRAM_LAT legal-range check.
- One natural sub-module: sram_inflight_pipe, the parameterised SRAM_LAT-deep {valid, owner, is_write} shift register with its response decode.

Test Plan:
- Fetch only, SRAM_LAT=1:
  - Stimulus: i_req=1, i_addr=0x1C000000 in cycle 0; SRAM returns 0x02800400.
  - Response: i_addr_ok=1, sram_en=1, sram_we=0 in cycle 0; i_data_ok=1, i_rdata=0x02800400 in cycle 1; d_data_ok stays 0.
- Conflict, fixed priority:
  - Stimulus: i_req=1 and d_req=1 (load, addr 0x100) both held from cycle 0.
  - Response: d_addr_ok=1 in cycle 0 and i_addr_ok=1 in cycle 1; d_data_ok in cycle 1, i_data_ok in cycle 2.
- Store:
  - Stimulus: d_req=1, d_wr=1, d_wstrb=4'b0011, d_addr=0x200, d_wdata=0xDEADBEEF.
  - Response: sram_we=4'b0011, sram_addr=0x200, sram_wdata=0xDEADBEEF in the grant cycle; d_data_ok one cycle later.
- SRAM_LAT=2 pipelining:
  - Stimulus: fetches to 0x0, 0x4, 0x8 in consecutive cycles 0-2.
  - Response: i_data_ok in cycles 2, 3, 4, in order, with matching rdata.
- Reset mid-flight:
  - Stimulus: grant a load in cycle 0, assert reset in cycle 1.
  - Response: no d_data_ok in cycles 1-3; all outputs 0 in cycle 2.
- SRAM_ARB_RR_EN defined:
  - Stimulus: both ports requesting continuously for 4 cycles.
  - Response: grants alternate I, D, I, D.
